data_mov_unit: RTL and testbench

//  Sequential load/store/move execution unit for the CPU datapath; replaces the

---
 rtl/data_mov_pkg.sv | 22 ++
 rtl/dm_timeout_ctr.sv | 53 +++++
 rtl/data_mov_unit.sv | 152 +++++++++++++++
 tb/tb_data_mov_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mov_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mov_pkg
//  Purpose  : Shared definitions for the data-move execution unit: opcode
//             encodings and the control FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package data_mov_pkg;

  localparam logic [4:0] OP_LDW = 5'b00001;
  localparam logic [4:0] OP_STW = 5'b00010;
  localparam logic [4:0] OP_MV  = 5'b00011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : data_mov_pkg
`default_nettype wire

// File: rtl/dm_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : dm_timeout_ctr
//  Purpose  : Bounded-wait counter for the memory request phase. Counts the
//             cycles a request has been outstanding and flags expiry on the
//             TIMEOUT-th cycle. TIMEOUT=0 disables the bound.
//  Ports    : clk      in  clock, rising edge
//             rst_n    in  async reset, active low
//             clear    in  restart the count (entry to request phase)
//             count_en in  request outstanding this cycle
//             expired  out this is the last allowed cycle of the request
//  Revision : 1.0  initial release
// ============================================================================
module dm_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      // Unbounded wait: the counter is not built.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, clear, count_en};
      assign expired       = 1'b0;
    end else begin : g_timeout
      localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

      logic [CW-1:0] cnt;

      // Count is 0 on the first request cycle, so reaching TIMEOUT-1 marks
      // the TIMEOUT-th cycle with the request held.
      assign expired = count_en && (cnt == LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (count_en && !expired) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule : dm_timeout_ctr
`default_nettype wire

// File: rtl/data_mov_unit.sv
`default_nettype none
// ============================================================================
//  Module   : data_mov_unit
//  Purpose  : Sequential LDW/STW/MV execution unit. Accepts one op via
//             valid/ready, runs a request/ack memory transaction for loads
//             and stores, and retires every op with a one-cycle done pulse
//             (plus a writeback pulse for MV and successful LDW).
//  Ports    : clk, rst_n                      clock / async active-low reset
//             in_valid, in_ready              op handshake (ready = IDLE)
//             opcode, has_imm, imm, x1, x2, rd   op fields
//             mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack
//                                             memory request/ack port
//             wb_valid, wb_rd, wb_data        writeback pulse
//             done, err                       retire pulse / error qualifier
//  Revision : 1.0  initial release
// ============================================================================
module data_mov_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int IMM_W   = 16,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic              has_imm,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [RD_W-1:0]   rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              done,
  output logic              err
);

  import data_mov_pkg::*;

  state_t state;

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] addr_sum;
  logic [DATA_W-1:0] mv_src;
  logic              accept;
  logic              is_mem_op;
  logic              expired;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign is_mem_op = (opcode == OP_LDW) || (opcode == OP_STW);

  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
  // Full-width add, then truncation to ADDR_W gives wrap mod 2^ADDR_W.
  assign addr_sum = x1 + (has_imm ? imm_sext : '0);
  assign mv_src   = has_imm ? imm_zext : x1;

  dm_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept && is_mem_op),
    .count_en (state == ST_REQ),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (opcode == OP_MV) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd;
              wb_data  <= mv_src;
              done     <= 1'b1;
              err      <= 1'b0;
              state    <= ST_DONE;
            end else if (is_mem_op) begin
              mem_req   <= 1'b1;
              mem_we    <= (opcode == OP_STW);
              mem_addr  <= addr_sum[ADDR_W-1:0];
              mem_wdata <= x2;
              wb_rd     <= rd;
              state     <= ST_REQ;
            end else begin
              // Illegal opcode: retire with error, memory untouched.
              done  <= 1'b1;
              err   <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_REQ: begin
          // Ack is checked first so an ack on the expiry cycle still succeeds.
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            if (!mem_we) begin
              wb_valid <= 1'b1;
              wb_data  <= mem_rdata;
            end
            state <= ST_DONE;
          end else if (expired) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          done     <= 1'b0;
          err      <= 1'b0;
          wb_valid <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : data_mov_unit
`default_nettype wire

// File: tb/tb_data_mov_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mov_unit
//  Purpose  : Self-checking bench for data_mov_unit. Expected retire results
//             are queued when an op is issued and compared when done pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mov_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int IMM_W   = 16;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 4;

  localparam logic [4:0] LDW = 5'b00001;
  localparam logic [4:0] STW = 5'b00010;
  localparam logic [4:0] MV  = 5'b00011;
  localparam logic [4:0] BAD = 5'b00111;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        opcode;
  logic              has_imm;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [RD_W-1:0]   rd;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  data_mov_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .IMM_W   (IMM_W),
    .RD_W    (RD_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .has_imm   (has_imm),
    .imm       (imm),
    .x1        (x1),
    .x2        (x2),
    .rd        (rd),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic              wbv;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic wbv, input logic [RD_W-1:0] r,
                      input logic [DATA_W-1:0] d, input logic e);
    exp_t x;
    x.wbv = wbv; x.rd = r; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  // Retire monitor: every done/wb_valid pulse must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (done || wb_valid)) begin
      if (sb.size() == 0) begin
        check("spurious_retire", {62'd0, wb_valid, done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done", done, 1);
        check("err", err, e.err);
        check("wb_valid", wb_valid, e.wbv);
        if (e.wbv) begin
          check("wb_rd", wb_rd, e.rd);
          check("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Called at posedge+1; issues the op on the next edge and returns at N+1.
  task automatic send(input logic [4:0] op, input logic hi, input logic [IMM_W-1:0] im,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [RD_W-1:0] r);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; opcode = op; has_imm = hi; imm = im; x1 = a; x2 = b; rd = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Walks the request phase: checks the held request each cycle, acks on
  // cycle ack_cyc (0 = never), and expects the request to drop after max_cyc.
  task automatic serve(input int ack_cyc, input int max_cyc, input logic [DATA_W-1:0] rdata,
                       input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    for (int c = 1; c <= max_cyc; c++) begin
      if (c == ack_cyc) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
      check("req_high", mem_req, 1);
      check("req_we", mem_we, we);
      check("req_addr", mem_addr, addr);
      if (we) check("req_wdata", mem_wdata, wdata);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    @(negedge clk);
    check("req_dropped", mem_req, 0);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; has_imm = 1'b0; imm = '0;
    x1 = '0; x2 = '0; rd = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MV with zero-extended immediate
    push(1, 5'd3, 32'h0000FFFE, 0);
    send(MV, 1, 16'hFFFE, 32'h0, 32'h0, 5'd3);
    @(negedge clk);
    check("mv_busy", in_ready, 0);
    check("mv_no_req", mem_req, 0);
    drain();

    // MV from register
    push(1, 5'd31, 32'h12345678, 0);
    send(MV, 0, 16'h8000, 32'h12345678, 32'h0, 5'd31);
    drain();

    // LDW, negative offset, ack on third request cycle
    push(1, 5'd7, 32'hDEADBEEF, 0);
    send(LDW, 1, 16'hFFFC, 32'h100, 32'h0, 5'd7);
    serve(3, 3, 32'hDEADBEEF, 0, 32'hFC, 32'h0);
    drain();

    // LDW address wrap
    push(1, 5'd1, 32'hA5A5A5A5, 0);
    send(LDW, 1, 16'h0002, 32'hFFFFFFFF, 32'h0, 5'd1);
    serve(2, 2, 32'hA5A5A5A5, 0, 32'h1, 32'h0);
    drain();

    // STW, ack in the first request cycle, no writeback
    push(0, 5'd0, 32'h0, 0);
    send(STW, 0, 16'h0010, 32'h200, 32'h55, 5'd2);
    serve(1, 1, 32'h0, 1, 32'h200, 32'h55);
    drain();

    // LDW timeout: request held TIMEOUT cycles, then error
    push(0, 5'd0, 32'h0, 1);
    send(LDW, 0, 16'h0, 32'h300, 32'h0, 5'd4);
    serve(0, TIMEOUT, 32'h0, 0, 32'h300, 32'h0);
    drain();

    // Ack on the expiry cycle wins
    push(1, 5'd4, 32'hCAFEF00D, 0);
    send(LDW, 0, 16'h0, 32'h300, 32'h0, 5'd4);
    serve(TIMEOUT, TIMEOUT, 32'hCAFEF00D, 0, 32'h300, 32'h0);
    drain();

    // STW timeout also errors without writeback
    push(0, 5'd0, 32'h0, 1);
    send(STW, 1, 16'h0004, 32'h400, 32'h77, 5'd5);
    serve(0, TIMEOUT, 32'h0, 1, 32'h404, 32'h77);
    drain();

    // Illegal opcode
    push(0, 5'd0, 32'h0, 1);
    send(BAD, 0, 16'h0, 32'h500, 32'h0, 5'd6);
    @(negedge clk);
    check("illegal_no_req", mem_req, 0);
    drain();
    @(negedge clk);
    check("illegal_no_req_after", mem_req, 0);
    @(posedge clk); #1;

    // Reset during the request phase, late ack ignored
    send(LDW, 0, 16'h0, 32'h600, 32'h0, 5'd9);
    @(negedge clk);
    check("rstmid_req_high", mem_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_req_drop", mem_req, 0);
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_done", done, 0);
    check("rstmid_wb_valid", wb_valid, 0);
    check("rstmid_addr", mem_addr, 0);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_done", done, 0);
      check("late_ack_wb", wb_valid, 0);
      check("late_ack_ready", in_ready, 1);
    end
    @(posedge clk); #1;

    // Normal operation after reset
    push(1, 5'd10, 32'h00001234, 0);
    send(MV, 1, 16'h1234, 32'h0, 32'h0, 5'd10);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_data_mov_unit
`default_nettype wire
